// File: rtl/adc_disp_pkg.sv
// Shared types and helpers for the ADC voltage display: FSM states, datapath
// widths and the active-low seven-segment decoder.
package adc_disp_pkg;

    localparam int MV_W   = 13;
    localparam int PROD_W = 21;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ADC = 3'd1,
        MULT     = 3'd2,
        BCD      = 3'd3,
        LOAD     = 3'd4
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 13-bit binary value to four BCD digits,
// one bit per cycle; the start cycle performs the first iteration.
module bin2bcd_seq
    import adc_disp_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [MV_W-1:0] bin,
    output logic            done,
    output logic [15:0]     bcd
);

    logic [MV_W-1:0] bin_sh;
    logic [3:0]      iter;
    logic            running;

    // Add 3 to every digit >= 5, then shift the next binary bit into the BCD field.
    function automatic logic [16+MV_W-1:0] dabble(input logic [15:0] b, input logic [MV_W-1:0] s);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return {adj, s} << 1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bin_sh  <= '0;
            bcd     <= '0;
            iter    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            if (start) begin
                {bcd, bin_sh} <= dabble(16'h0000, bin);
                iter          <= 4'd1;
                running       <= 1'b1;
            end else if (running) begin
                {bcd, bin_sh} <= dabble(bcd, bin_sh);
                iter          <= iter + 4'd1;
                if (iter == 4'(MV_W - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_volt_display.sv
// Paces TLC549 conversions, scales each code to mV, converts to BCD and scans a
// 4-digit "X.XXX" display. Define ADC_AVG4_EN to average four captures per update.
module adc_volt_display
    import adc_disp_pkg::*;
#(
    parameter int              SAMPLE_DIV = 2500000,
    parameter int              SCAN_DIV   = 50000,
    parameter logic [MV_W-1:0] VREF_MV    = 13'd5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        adc_data_ready,
    input  logic [7:0]  adc_data,
    output logic        adc_enable,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [7:0]  seg,
    output logic [3:0]  dig
);

    localparam int SW  = $clog2(SAMPLE_DIV);
    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t            state;
    logic [SW-1:0]     sample_cnt;
    logic              tick;
    logic              pending;
    logic [7:0]        mul_sh;
    logic [2:0]        mul_step;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] prod_next;
    logic              bcd_start;
    logic              bcd_done;
    logic [15:0]       bcd_result;
    logic [MV_W-1:0]   mv;
    logic [SCW-1:0]    scan_cnt;
    logic [1:0]        digit_sel;

`ifdef ADC_AVG4_EN
    logic [9:0]        acc;
    logic [1:0]        avg_idx;
    logic [9:0]        sum_next;
    assign sum_next = acc + 10'(adc_data);
`endif

    assign tick = (sample_cnt == SW'(SAMPLE_DIV - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sample_cnt <= '0;
        else if (tick)
            sample_cnt <= '0;
        else
            sample_cnt <= sample_cnt + 1'b1;
    end

    always_comb begin
        // NOTE: default assignment first so no latch is inferred when mul_sh[0] is 0.
        addend = '0;
        if (mul_sh[0])
            addend = PROD_W'(VREF_MV) << mul_step;
        prod_next = prod + addend;
    end

    // The BCD converter starts on the final multiply step, fed the completed product.
    assign mv        = prod_next[PROD_W-1 -: MV_W];
    assign bcd_start = (state == MULT) && (mul_step == 3'd7);

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (bcd_start),
        .bin   (mv),
        .done  (bcd_done),
        .bcd   (bcd_result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            adc_enable <= 1'b0;
            pending    <= 1'b0;
            mul_sh     <= '0;
            mul_step   <= '0;
            prod       <= '0;
            bcd        <= '0;
            bcd_valid  <= 1'b0;
`ifdef ADC_AVG4_EN
            acc        <= '0;
            avg_idx    <= '0;
`endif
        end else begin
            bcd_valid <= 1'b0;
            if (tick && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick || pending) begin
                        state      <= WAIT_ADC;
                        adc_enable <= 1'b1;
                        pending    <= 1'b0;
                    end
                end
                WAIT_ADC: begin
                    if (adc_data_ready) begin
                        adc_enable <= 1'b0;
                        prod       <= '0;
                        mul_step   <= '0;
`ifdef ADC_AVG4_EN
                        if (avg_idx == 2'd3) begin
                            mul_sh <= sum_next[9:2];
                            state  <= MULT;
                        end else begin
                            acc     <= sum_next;
                            avg_idx <= avg_idx + 2'd1;
                            state   <= IDLE;
                        end
`else
                        mul_sh <= adc_data;
                        state  <= MULT;
`endif
                    end
                end
                MULT: begin
                    prod     <= prod_next;
                    mul_sh   <= mul_sh >> 1;
                    mul_step <= mul_step + 3'd1;
                    if (mul_step == 3'd7)
                        state <= BCD;
                end
                BCD: begin
                    if (bcd_done)
                        state <= LOAD;
                end
                LOAD: begin
                    bcd       <= bcd_result;
                    bcd_valid <= 1'b1;
                    state     <= IDLE;
`ifdef ADC_AVG4_EN
                    acc       <= '0;
                    avg_idx   <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display scan reads only the registered bcd, so mid-conversion values never show.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_sel <= '0;
            seg       <= 8'hFF;
            dig       <= 4'hF;
        end else begin
            if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            dig <= ~(4'b0001 << digit_sel);
            seg <= {digit_sel != 2'd3, seg_decode(bcd[{digit_sel, 2'b00} +: 4])};
        end
    end

endmodule

// File: tb/tb_adc_volt_display.sv
// Scoreboard bench for adc_volt_display: stimulus pushes expected BCD results
// with their due cycle; a monitor pops and compares on every bcd_valid.
`timescale 1ns/1ps
module tb_adc_volt_display;

    localparam int SAMPLE_DIV = 64;
    localparam int SCAN_DIV   = 4;
    localparam int LAT        = 23;   // drive negedge to the negedge where bcd_valid is seen

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        adc_data_ready = 1'b0;
    logic [7:0]  adc_data = 8'h00;
    logic        adc_enable;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  seg;
    logic [3:0]  dig;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int t_end;

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [7:0] avg_codes [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

    adc_volt_display #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .VREF_MV    (13'd5000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .adc_data_ready (adc_data_ready),
        .adc_data       (adc_data),
        .adc_enable     (adc_enable),
        .bcd            (bcd),
        .bcd_valid      (bcd_valid),
        .busy           (busy),
        .seg            (seg),
        .dig            (dig)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        if (reset && bcd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_bcd_valid", 32'(bcd_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_value", 32'(bcd), 32'(e.val));
                check("bcd_latency", cyc, e.at);
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge clock);
            guard++;
            if (guard > 5000) begin
                $display("FAIL wait_cyc: stuck at cycle %0d waiting for %0d", cyc, n);
                $fatal(1, "wait bound expired");
            end
        end
    endtask

    task automatic strobe(input logic [7:0] d, input logic push, input logic [15:0] exp_val);
        if (push) begin
            exp_t e;
            e.val = exp_val;
            e.at  = cyc + LAT;
            sb.push_back(e);
        end
        adc_data       = d;
        adc_data_ready = 1'b1;
        @(negedge clock);
        adc_data_ready = 1'b0;
        adc_data       = 8'($urandom);
        check("enable_low_after_strobe", 32'(adc_enable), 32'd0);
    endtask

    task automatic check_digits(input logic [15:0] v);
        for (int d = 0; d < 4; d++) begin
            int         guard;
            logic [3:0] want;
            guard = 0;
            want  = ~(4'b0001 << d);
            while (dig !== want && guard < 8 * SCAN_DIV) begin
                @(negedge clock);
                guard++;
            end
            check($sformatf("dig%0d_select", d), 32'(dig), 32'(want));
            check($sformatf("dig%0d_seg", d), 32'(seg), 32'({(d != 3), seg_tab[v[4*d +: 4]]}));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},        32'(seg),        32'hFF);
        check({tag, "_dig"},        32'(dig),        32'hF);
        check({tag, "_adc_enable"}, 32'(adc_enable), 32'd0);
        check({tag, "_bcd"},        32'(bcd),        32'h0000);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_bcd_valid"},  32'(bcd_valid),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            adc_data       = 8'($urandom);
            adc_data_ready = 1'($urandom);
            @(negedge clock);
        end
        check_reset_outputs("reset_hold");
        adc_data_ready = 1'b0;
        reset = 1'b1;

        wait_cyc(SAMPLE_DIV - 1);
        check("enable_before_tick", 32'(adc_enable), 32'd0);
        check("busy_before_tick", 32'(busy), 32'd0);
        wait_cyc(SAMPLE_DIV);
        check("enable_at_tick", 32'(adc_enable), 32'd1);
        check("busy_at_tick", 32'(busy), 32'd1);

`ifdef ADC_AVG4_EN
        for (int i = 0; i < 4; i++) begin
            int guard = 0;
            while (adc_enable !== 1'b1 && guard < 3 * SAMPLE_DIV) begin
                @(negedge clock);
                guard++;
            end
            check("avg_enable", 32'(adc_enable), 32'd1);
            @(negedge clock);
            @(negedge clock);
            strobe(avg_codes[i], i == 3, 16'h0781);
        end
        t_end = cyc + 40;
        wait_cyc(t_end);
        check("avg_bcd", 32'(bcd), 32'h0781);
        check_digits(16'h0781);
`else
        wait_cyc(70);
        strobe(8'hFF, 1'b1, 16'h4980);
        wait_cyc(73);
        strobe(8'h11, 1'b0, 16'h0000);        // lands in MULT: ignored
        wait_cyc(100);
        strobe(8'h22, 1'b0, 16'h0000);        // lands in IDLE: ignored
        wait_cyc(110);
        check("bcd_hold_after_ignored", 32'(bcd), 32'h4980);
        check("busy_idle", 32'(busy), 32'd0);
        check_digits(16'h4980);

        // Tick at edge 192 falls inside BCD, so the next request follows LOAD at once.
        wait_cyc(175);
        strobe(8'h00, 1'b1, 16'h0000);
        wait_cyc(198);
        check("enable_low_at_load_exit", 32'(adc_enable), 32'd0);
        wait_cyc(199);
        check("enable_from_pending", 32'(adc_enable), 32'd1);
        check_digits(16'h0000);

        wait_cyc(240);
        strobe(8'h80, 1'b1, 16'h2500);
        wait_cyc(270);
        check("bcd_2500", 32'(bcd), 32'h2500);

        // Conversion of 0x40 is cut off by reset in BCD; its result must never appear.
        wait_cyc(280);
        strobe(8'h40, 1'b1, 16'h1250);
        wait_cyc(295);
        check("busy_in_bcd", 32'(busy), 32'd1);
        reset = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("reset_mid_bcd");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(40);
        check("bcd_after_reset", 32'(bcd), 32'h0000);
        check("enable_after_reset", 32'(adc_enable), 32'd0);
        wait_cyc(SAMPLE_DIV);
        check("enable_restart", 32'(adc_enable), 32'd1);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_volt_display.md
Name: adc_volt_display

Overview:
- Downstream consumer of the TLC549 serial ADC reader. Paces conversions by driving that block's enable, and captures each 8-bit result on its data_ready strobe.
- Scales each result to millivolts and converts it to 4-digit BCD with a sequential double-dabble.
- Drives a multiplexed 4-digit seven-segment display showing X.XXX volts.

Parameters:
- SAMPLE_DIV, 2500000: clock cycles between sample requests (≥ 64).
- SCAN_DIV, 50000: clock cycles each display digit stays lit (≥ 2).
- VREF_MV, 5000: ADC full-scale reference in mV, 13-bit, ≤ 8191.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- adc_data_ready  in  1  one-cycle strobe from ADC reader, marks adc_data valid.
- adc_data  in  8  ADC conversion result.
- adc_enable  out  1  conversion request to ADC reader, level.
- bcd  out  16  last result in BCD: [15:12] thousands … [3:0] units, in mV.
- bcd_valid  out  1  one-cycle pulse when bcd updates.
- busy  out  1  high in any state other than IDLE.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- dig  out  4  digit select, active-low; dig[3] is the leftmost digit.

Behaviour:
- Reset (reset=0, async): state=IDLE, adc_enable=0, bcd=16'h0000, bcd_valid=0, busy=0, seg=8'hFF, dig=4'hF, all counters 0, pending=0.
- Sample timer: free-running 0..SAMPLE_DIV-1; tick=1 for one cycle at the wrap.
  - Tick in IDLE starts a cycle.
  - Tick in any other state sets pending (1 bit, saturating; further ticks are lost).
  - IDLE with pending=1 starts a cycle and clears pending.
- FSM states: IDLE, WAIT_ADC, MULT, BCD, LOAD.
  - IDLE -> WAIT_ADC on tick or pending.
  - WAIT_ADC: adc_enable=1. On adc_data_ready=1, capture adc_data, drop adc_enable on the next cycle, go to MULT. adc_data_ready outside WAIT_ADC is ignored.
  - MULT: 8-cycle shift-add of code×VREF_MV into a 21-bit product; mv = product[20:8] (divide by 256, truncated). Max is 255×5000>>8 = 4980.
  - BCD: 13-cycle double-dabble of mv into 4 BCD digits via bin2bcd_seq.
  - LOAD: bcd <= result, bcd_valid=1 for this cycle only; next state IDLE.
- Latency: bcd_valid is high exactly 22 cycles after the edge that samples adc_data_ready (MULT 8, BCD 13, LOAD 1).
- mv exceeding 9999 cannot occur given VREF_MV ≤ 8191; no saturation logic.
- Display scan:
  - Digit counter advances every SCAN_DIV cycles, order 0→1→2→3→0.
  - The active digit's dig bit is low; the other three are high.
  - seg shows the decoded bcd nibble. dp is lit only on digit 3, giving "X.XXX".
  - No leading-zero blanking. Nibbles above 9 show all segments off.
  - The display reads the registered bcd, so updates are glitch-free.
- Reset mid-operation returns to the reset state immediately. A partially computed result is discarded, and no bcd_valid is issued.

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined: four consecutive captures accumulate into a 10-bit sum. The FSM loops IDLE→WAIT_ADC four times, using pending/ticks as normal. MULT then uses sum[9:2], so bcd_valid comes once per 4 samples. A 2-bit sample index and the accumulator are cleared at reset and after LOAD.
- Undefined: every capture is converted and displayed.

Decomposition:
- Package adc_disp_pkg:
  - FSM state encoding constants.
  - Seven-segment decode function, nibble → active-low {g..a}.
  - Segment value SEG_BLANK = 7'h7F.
  - Widths MV_W=13 and PROD_W=21.
- Sub-module bin2bcd_seq:
  - Inputs: start, bin[12:0].
  - Outputs: done, bcd[15:0].
  - Behaviour: 13-cycle double-dabble.
- The multiplier stays inline.

Test Plan:
- Reset held with random inputs -> seg=8'hFF, dig=4'hF, adc_enable=0, bcd=16'h0000, busy=0; release, wait SAMPLE_DIV -> adc_enable=1.
- In WAIT_ADC, strobe adc_data=8'hFF -> bcd=16'h4980 with a bcd_valid pulse 22 cycles later; when dig=4'b0111, seg shows '4' with dp low.
- adc_data=8'h80 -> bcd=16'h2500; adc_data=8'h00 -> bcd=16'h0000, all four digits show '0'.
- adc_data_ready pulsed in IDLE and in MULT -> no capture, bcd unchanged, no bcd_valid. Tick during BCD -> adc_enable rises the cycle after LOAD→IDLE.
- reset asserted during the BCD state -> outputs return to reset values at once, no bcd_valid; the previous bcd is cleared to 0.
- With ADC_AVG4_EN, captures 8'h10, 8'h20, 8'h30, 8'h40 -> code 8'h28 (40) -> bcd=16'h0781 (40×5000>>8 = 781); exactly one bcd_valid.
